// File: rtl/arm_cond_pkg.sv
// Shared encodings for ARM condition evaluation in the EXE stage:
// cond field codes, CPSR flag bit positions and the EXE controller FSM states.
package arm_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } exe_state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition check of a cond field against the {N,Z,C,V} flags.
module cond_eval
    import arm_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/exe_cond_ctrl.sv
// EXE-stage conditional-execution controller: CPSR flags, enable squashing,
// branch flush sequencing and executed/squashed debug counters.
module exe_cond_ctrl
    import arm_cond_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             valid_in,
    input  logic [3:0]       cond_in,
    input  logic             s_in,
    input  logic             wb_en_in,
    input  logic             mem_r_en_in,
    input  logic             mem_w_en_in,
    input  logic             b_in,
    input  logic [3:0]       alu_status,
    output logic [3:0]       status,
    output logic             exec_ok,
    output logic             wb_en_out,
    output logic             mem_r_en_out,
    output logic             mem_w_en_out,
    output logic             branch_taken,
    output logic             flush,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [3:0] SHADOW_LOAD = 4'(FLUSH_CYCLES - 1);

    exe_state_t       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       status_q, status_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
    logic             pass;

    cond_eval u_cond_eval (
        .cond  (cond_in),
        .flags (status_q),
        .pass  (pass)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            status_q     <= '0;
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            status_q     <= status_d;
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    // Next state: a taken branch opens a shadow window of FLUSH_CYCLES-1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!freeze) begin
            case (state_q)
                ST_RUN: begin
                    if (branch_taken && (FLUSH_CYCLES > 1)) begin
                        state_d = ST_SHADOW;
                        cnt_d   = SHADOW_LOAD;
                    end
                end
                ST_SHADOW: begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        exec_ok      = valid_in & pass & (state_q == ST_RUN);
        wb_en_out    = wb_en_in & exec_ok;
        mem_r_en_out = mem_r_en_in & exec_ok;
        mem_w_en_out = mem_w_en_in & exec_ok;
        branch_taken = b_in & exec_ok & ~freeze;
        flush        = branch_taken | ((state_q == ST_SHADOW) & ~freeze);
    end

    always_comb begin
        status_d     = status_q;
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (!freeze) begin
            if (exec_ok && s_in) begin
                status_d = alu_status;
            end
            if (valid_in) begin
                if (exec_ok) begin
                    exec_cnt_d = exec_cnt_q + CNT_W'(1);
                end else begin
                    squash_cnt_d = squash_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign status     = status_q;
    assign exec_cnt   = exec_cnt_q;
    assign squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_exe_cond_ctrl.sv
// Self-checking bench for exe_cond_ctrl: directed scenarios plus random traffic
// compared against a behavioural model of the condition/flush/counter rules.
module tb_exe_cond_ctrl;

    localparam int FC = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, freeze, valid_in, s_in;
    logic          wb_en_in, mem_r_en_in, mem_w_en_in, b_in;
    logic [3:0]    cond_in, alu_status;
    logic [3:0]    status;
    logic          exec_ok, wb_en_out, mem_r_en_out, mem_w_en_out;
    logic          branch_taken, flush;
    logic [CW-1:0] exec_cnt, squash_cnt;

    int checks = 0;
    int errors = 0;

    logic [3:0]    m_status;
    int            m_left;
    logic [CW-1:0] m_exec, m_squash;
    logic [CW-1:0] sq_before;

    exe_cond_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .valid_in     (valid_in),
        .cond_in      (cond_in),
        .s_in         (s_in),
        .wb_en_in     (wb_en_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .b_in         (b_in),
        .alu_status   (alu_status),
        .status       (status),
        .exec_ok      (exec_ok),
        .wb_en_out    (wb_en_out),
        .mem_r_en_out (mem_r_en_out),
        .mem_w_en_out (mem_w_en_out),
        .branch_taken (branch_taken),
        .flush        (flush),
        .exec_cnt     (exec_cnt),
        .squash_cnt   (squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ARM groups conditions in pairs: odd codes are the negation of the even one.
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ c[0];
    endfunction

    // Called at negedge with inputs set: check outputs, advance one clock, update model.
    task automatic step();
        bit ok, bt, fl;
        #2;
        ok = valid_in && (m_left == 0) && ref_pass(cond_in, m_status);
        bt = b_in && ok && !freeze;
        fl = bt || ((m_left > 0) && !freeze);
        check("status",     32'(status),       32'(m_status));
        check("exec_ok",    32'(exec_ok),      32'(ok));
        check("wb_en",      32'(wb_en_out),    32'(wb_en_in && ok));
        check("mem_r_en",   32'(mem_r_en_out), 32'(mem_r_en_in && ok));
        check("mem_w_en",   32'(mem_w_en_out), 32'(mem_w_en_in && ok));
        check("branch",     32'(branch_taken), 32'(bt));
        check("flush",      32'(flush),        32'(fl));
        check("exec_cnt",   32'(exec_cnt),     32'(m_exec));
        check("squash_cnt", 32'(squash_cnt),   32'(m_squash));
        @(posedge clk);
        if (rst) begin
            m_status = '0; m_left = 0; m_exec = '0; m_squash = '0;
        end else if (!freeze) begin
            if (m_left > 0) m_left = m_left - 1;
            else if (bt) m_left = FC - 1;
            if (ok && s_in) m_status = alu_status;
            if (valid_in) begin
                if (ok) m_exec = m_exec + 1'b1;
                else    m_squash = m_squash + 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_in(input bit v, input logic [3:0] c, input bit s, input bit b,
                          input logic [3:0] alu);
        valid_in = v; cond_in = c; s_in = s; b_in = b; alu_status = alu;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0;
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        set_in(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        m_status = '0; m_left = 0; m_exec = '0; m_squash = '0;
        @(posedge clk);
        @(negedge clk);
        step();
        rst = 1'b0;

        // Z=0 after reset: EQ fails, NE passes
        wb_en_in = 1'b1;
        set_in(1'b1, 4'h0, 1'b0, 1'b0, 4'h0); step();
        check("tp1_squash", 32'(squash_cnt), 32'd1);
        set_in(1'b1, 4'h1, 1'b0, 1'b0, 4'h0); step();
        check("tp1_exec", 32'(exec_cnt), 32'd1);

        set_in(1'b1, 4'hE, 1'b1, 1'b0, 4'b0100); step();
        check("tp2_status", 32'(status), 32'h4);
        mem_w_en_in = 1'b1;
        set_in(1'b1, 4'h0, 1'b0, 1'b0, 4'h0); step();
        mem_w_en_in = 1'b0;

        set_in(1'b1, 4'h1, 1'b1, 1'b0, 4'b1011); step();
        check("tp3_status", 32'(status), 32'h4);

        // Taken branch: two shadow cycles squash even AL instructions
        sq_before = squash_cnt;
        set_in(1'b1, 4'hE, 1'b0, 1'b1, 4'h0); step();
        set_in(1'b1, 4'hE, 1'b0, 1'b0, 4'h0); step(); step();
        check("tp4_squash", 32'(squash_cnt), 32'(sq_before + 2'd2));
        step();

        set_in(1'b1, 4'hE, 1'b0, 1'b1, 4'h0); step();
        set_in(1'b1, 4'hE, 1'b0, 1'b0, 4'h0);
        freeze = 1'b1; step(); step();
        freeze = 1'b0; step(); step(); step();

        set_in(1'b1, 4'hE, 1'b1, 1'b0, 4'b1000); step();
        s_in = 1'b0;
        for (int c = 10; c <= 13; c++) begin cond_in = 4'(c); step(); end
        set_in(1'b1, 4'hE, 1'b1, 1'b0, 4'b0110); step();
        s_in = 1'b0;
        cond_in = 4'h8; step();
        cond_in = 4'h9; step();

        set_in(1'b1, 4'hE, 1'b0, 1'b1, 4'h0); step();
        b_in = 1'b0; rst = 1'b1; step();
        rst = 1'b0; step();
        check("tp6_flush", 32'(flush), 32'd0);
        check("tp6_status", 32'(status), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            rst         = ($urandom_range(0, 63) == 0);
            freeze      = ($urandom_range(0, 3) == 0);
            valid_in    = ($urandom_range(0, 7) != 0);
            cond_in     = 4'($urandom_range(0, 15));
            s_in        = 1'($urandom);
            b_in        = ($urandom_range(0, 3) == 0);
            wb_en_in    = 1'($urandom);
            mem_r_en_in = 1'($urandom);
            mem_w_en_in = 1'($urandom);
            alu_status  = 4'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_cond_ctrl.md
Name: exe_cond_ctrl

Overview:
- EXE-stage conditional-execution controller for the 5-stage ARM pipeline.
- Owns the CPSR flag register (N,Z,C,V) and evaluates each EXE instruction's cond field against it.
- Squashes write-back and memory enables of failed instructions, commits S-bit flag updates, and sequences branch flush of IF/ID and ID/EX over a programmable number of cycles.
- Keeps executed/squashed event counters for lab debug.

Parameters:
- FLUSH_CYCLES, 2, total cycles flush is asserted per taken branch, including the branch cycle; legal 1..15.
- CNT_W, 16, width of the debug event counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  global pipeline stall (hazard or memory wait).
- valid_in  in  1  ID/EX holds a real instruction.
- cond_in  in  4  instruction cond field, ARM encoding (EQ=0000 … AL=1110, 1111=never).
- s_in  in  1  instruction S bit.
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in  in  1 each  decoded control bits from ID/EX.
- alu_status  in  4  {N,Z,C,V} produced by the ALU this cycle.
- status  out  4  current flag register {N,Z,C,V}; feeds the ALU carry-in.
- exec_ok  out  1  the instruction in EXE passes its condition and is not shadow-squashed.
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  gated enables.
- branch_taken  out  1  PC-select to the branch target.
- flush  out  1  clears IF/ID and ID/EX.
- exec_cnt, squash_cnt  out  CNT_W each  debug counters.

Behaviour:
- Reset, synchronous, wins over all inputs:
  - status=0000, FSM=RUN, flush counter=0, exec_cnt=squash_cnt=0.
  - All combinational outputs follow from these values.
- Condition pass, combinational from the registered status only (never from alu_status):
  - EQ z; NE ~z; CS c; CC ~c; MI n; PL ~n; VS v; VC ~v.
  - HI c&~z; LS ~c|z; GE n==v; LT n!=v; GT ~z&(n==v); LE z|(n!=v); AL 1; 1111 → 0.
- FSM states:
  - RUN: exec_ok = valid_in & pass.
  - SHADOW: exec_ok = 0 for every instruction; these are wrong-path instructions.
- Gated enables, combinational: wb_en_out = wb_en_in & exec_ok; same for mem_r and mem_w.
- Branch and flush, combinational:
  - branch_taken = b_in & exec_ok & ~freeze.
  - flush = branch_taken | (state==SHADOW & ~freeze).
- Transitions, evaluated at the clock edge, only when ~freeze:
  - RUN → SHADOW on branch_taken when FLUSH_CYCLES>1; load cnt = FLUSH_CYCLES-1.
  - SHADOW: decrement cnt each cycle; return to RUN on the cycle cnt reaches 1.
  - FLUSH_CYCLES=1: never enter SHADOW; flush lasts only the branch cycle.
  - A taken branch cannot occur in SHADOW, because exec_ok=0 there.
- Flag update, at the edge when ~freeze & exec_ok & s_in: status <= alu_status.
  - A branch with S set updates flags and branches in the same cycle.
  - Failed or squashed S instructions leave status unchanged.
- Counters, at the edge when ~freeze & valid_in:
  - exec_cnt+1 if exec_ok, else squash_cnt+1.
  - Both wrap modulo 2^CNT_W.
- freeze=1:
  - FSM, shadow counter, status and counters hold.
  - branch_taken=0 and flush=0.
  - Gated enables still reflect condition pass; downstream registers hold anyway.
- Reset mid-SHADOW: back to RUN next cycle; remaining shadow cycles are dropped.

Decomposition:
- Package arm_cond_pkg:
  - 4-bit cond encodings COND_EQ…COND_AL, COND_NV.
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FSM state encoding ST_RUN, ST_SHADOW.
- One sub-module: cond_eval (combinational cond + status → pass).
- FSM, flag register and counters stay in exe_cond_ctrl.

Test Plan:
- Reset then valid_in=1, cond=EQ(0000), wb_en_in=1 → exec_ok=0, wb_en_out=0, squash_cnt=1; then cond=NE(0001) → exec_ok=1, wb_en_out=1, exec_cnt=1.
- S instruction: cond=AL, s_in=1, alu_status=0100 → status=0100 next cycle; following cond=EQ with mem_w_en_in=1 → mem_w_en_out=1.
- Failed S instruction: status=0100, cond=NE, s_in=1, alu_status=1011 → status stays 0100, exec_ok=0.
- FLUSH_CYCLES=3, taken branch (cond=AL, b_in=1) → branch_taken=1 and flush=1 that cycle; flush=1 for 2 more cycles with exec_ok=0 even for valid cond=AL inputs; squash_cnt +2; RUN on the 4th cycle.
- Freeze in SHADOW: assert freeze for 2 cycles after the branch cycle → flush=0 while frozen, shadow count preserved; flush resumes for the remaining cycles after release.
- Signed conditions: status N=1,V=0,Z=0 → LT pass, GE fail, GT fail, LE pass; status Z=1,C=1 → HI fail, LS pass; rst asserted mid-SHADOW → flush=0 and status=0000 next cycle.
